// File: rtl/fsk_decoder_defs.sv
// Shared encodings and rate derivation for the FSK byte decoder.
package fsk_decoder_defs;

  // Framing FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } fsm_state_t;

  // Per-window tone decision
  typedef enum logic [1:0] {
    BIT0  = 2'd0,
    BIT1  = 2'd1,
    AMBIG = 2'd2
  } decision_t;

  // Clocks per bit window
  function automatic int calc_bit_clocks(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/fsk_window_decider.sv
// Bit-window timing and tone decision: differences the cumulative tone
// counters once per window and reports a registered 0/1/ambiguous result.
module fsk_window_decider
  import fsk_decoder_defs::*;
#(
  parameter int BIT_CLOCKS = 10,
  parameter int MIN_MARGIN = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] f0_value,
  input  logic [31:0] f1_value,
  output logic        strobe,
  output logic        value,
  output logic        ambig
);

  localparam int WW = (BIT_CLOCKS > 1) ? $clog2(BIT_CLOCKS) : 1;

  logic [WW-1:0] wcnt;
  logic [31:0]   prev0, prev1;
  logic [31:0]   d0, d1;
  logic          primed;
  logic          win_end;
  decision_t     dec;

  assign win_end = enable && (wcnt == WW'(BIT_CLOCKS - 1));

  // Modular differences: a counter wrap between snapshots still yields the true delta
  assign d0 = f0_value - prev0;
  assign d1 = f1_value - prev1;

  // Margin compare in 33 bits so adding the margin can never overflow
  always_comb begin
    dec = AMBIG;
    if ({1'b0, d1} >= ({1'b0, d0} + 33'(MIN_MARGIN)))
      dec = BIT1;
    else if ({1'b0, d0} >= ({1'b0, d1} + 33'(MIN_MARGIN)))
      dec = BIT0;
  end

  // Window counter: free-runs while enabled, parked at 0 otherwise
  always_ff @(posedge clock or posedge clear) begin
    if (clear)        wcnt <= '0;
    else if (!enable) wcnt <= '0;
    else if (win_end) wcnt <= '0;
    else              wcnt <= wcnt + 1'b1;
  end

  // Snapshots: follow the inputs while disabled so re-enable sees no stale delta
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      prev0 <= '0;
      prev1 <= '0;
    end else if (!enable || win_end) begin
      prev0 <= f0_value;
      prev1 <= f1_value;
    end
  end

  // Primed flag: the first window after reset/enable has a meaningless delta
  always_ff @(posedge clock or posedge clear) begin
    if (clear)        primed <= 1'b0;
    else if (!enable) primed <= 1'b0;
    else if (win_end) primed <= 1'b1;
  end

  // Registered decision, one cycle after the window end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      strobe <= 1'b0;
      value  <= 1'b0;
      ambig  <= 1'b0;
    end else begin
      strobe <= win_end && primed && (dec != AMBIG);
      value  <= win_end && primed && (dec == BIT1);
      ambig  <= win_end && primed && (dec == AMBIG);
    end
  end

endmodule

// File: rtl/fsk_byte_decoder.sv
// FSK byte decoder: UART-style framing of window decisions into bytes,
// delivered over valid/ready with framing, carrier-loss and overrun flags.
module fsk_byte_decoder
  import fsk_decoder_defs::*;
#(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 1000,
  parameter int MIN_MARGIN      = 2,
  parameter int DATA_BITS       = 8
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [31:0]          f0_value,
  input  logic [31:0]          f1_value,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 bit_strobe,
  output logic                 bit_value,
  output logic                 framing_error,
  output logic                 carrier_lost,
  output logic                 overrun
);

  localparam int BIT_CLOCKS = calc_bit_clocks(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int IW         = $clog2(DATA_BITS + 1);

  generate
    if (BIT_CLOCKS < 4) begin : g_bad_rate
      $error("fsk_byte_decoder: CLOCK_FREQUENCY/BAUD_RATE must be at least 4");
    end
  endgenerate

  logic                 strobe, value, amb;
  fsm_state_t           state, state_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 load_req, fe_req, cl_req;

  fsk_window_decider #(
    .BIT_CLOCKS (BIT_CLOCKS),
    .MIN_MARGIN (MIN_MARGIN)
  ) u_dec (
    .clock    (clock),
    .clear    (clear),
    .enable   (enable),
    .f0_value (f0_value),
    .f1_value (f1_value),
    .strobe   (strobe),
    .value    (value),
    .ambig    (amb)
  );

  assign bit_strobe = strobe;
  assign bit_value  = value;

  // Framing state register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
    end
  end

  // Next-state: start bit opens a frame, data shifts in LSB-first, stop closes it
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      shreg_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe && !value) begin
            state_nxt = DATA;
            idx_nxt   = '0;
            shreg_nxt = '0;
          end
        end
        DATA: begin
          if (strobe) begin
            shreg_nxt = {value, shreg[DATA_BITS-1:1]};
            idx_nxt   = idx + 1'b1;
            if (idx == IW'(DATA_BITS - 1)) state_nxt = STOP;
          end else if (amb) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            shreg_nxt = '0;
          end
        end
        STOP: begin
          // A 0 here is a bad stop bit, never a fresh start bit
          if (strobe || amb) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: byte load and error requests, registered below
  always_comb begin
    load_req = 1'b0;
    fe_req   = 1'b0;
    cl_req   = 1'b0;
    if (enable) begin
      case (state)
        DATA: cl_req = amb;
        STOP: begin
          load_req = strobe && value;
          fe_req   = strobe && !value;
          cl_req   = amb;
        end
        default: ;
      endcase
    end
  end

  // One-cycle error pulses
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      framing_error <= 1'b0;
      carrier_lost  <= 1'b0;
    end else begin
      framing_error <= fe_req;
      carrier_lost  <= cl_req;
    end
  end

  // Holding register: a load wins over a same-cycle transfer; a load into a
  // full, stalled register is dropped and latches overrun
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (load_req && (!data_valid || data_ready)) begin
      data_out   <= shreg;
      data_valid <= 1'b1;
    end else begin
      if (load_req)                 overrun    <= 1'b1;
      if (data_valid && data_ready) data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fsk_byte_decoder.sv
// Scoreboard bench for fsk_byte_decoder: tone windows are driven per bit,
// expected bytes queued at send time and popped on each handshake.
module tb_fsk_byte_decoder;

  logic        clock = 1'b0;
  logic        clear, enable, data_ready;
  logic [31:0] f0_value, f1_value;
  logic [7:0]  data_out;
  logic        data_valid, bit_strobe, bit_value;
  logic        framing_error, carrier_lost, overrun;

  int checks = 0, failures = 0;
  int n_strobe = 0, n_fe = 0, n_cl = 0, n_vcyc = 0, cyc = 0;
  int last_strobe_cyc = -100;
  int exp_strobe = 0;
  bit skip = 1'b1, prev_valid = 1'b0, last_bit = 1'b0;
  logic [7:0] exp_q[$];

  fsk_byte_decoder #(
    .CLOCK_FREQUENCY (1000),
    .BAUD_RATE       (100),
    .MIN_MARGIN      (2),
    .DATA_BITS       (8)
  ) dut (
    .clock         (clock),
    .clear         (clear),
    .enable        (enable),
    .f0_value      (f0_value),
    .f1_value      (f1_value),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .bit_strobe    (bit_strobe),
    .bit_value     (bit_value),
    .framing_error (framing_error),
    .carrier_lost  (carrier_lost),
    .overrun       (overrun)
  );

  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: counts pulses, checks load latency, pops scoreboard on transfer
  always begin
    @(negedge clock);
    #1;
    cyc++;
    if (bit_strobe) begin
      n_strobe++;
      last_strobe_cyc = cyc;
      last_bit = bit_value;
    end
    if (framing_error) n_fe++;
    if (carrier_lost)  n_cl++;
    if (data_valid) begin
      n_vcyc++;
      if (!prev_valid) chk("valid_lat", cyc - last_strobe_cyc, 1);
      if (data_ready) begin
        chk("sb_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("sb_byte", data_out, exp_q.pop_front());
      end
    end
    prev_valid = data_valid;
  end

  // One bit window (10 clocks); tone counts step mid-window
  task automatic win(input int unsigned a0, input int unsigned a1);
    repeat (5) @(negedge clock);
    f0_value = f0_value + a0;
    f1_value = f1_value + a1;
    repeat (5) @(negedge clock);
    if (skip) skip = 1'b0;
    else if (a1 >= a0 + 2 || a0 >= a1 + 2) exp_strobe++;
  endtask

  task automatic send_bit(input bit b);
    if (b) win(0, 5);
    else   win(5, 0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
  endtask

  initial begin
    int s_fe, s_cl, s_v, s_s;
    clear = 1'b1; enable = 1'b0; data_ready = 1'b1;
    f0_value = 32'd100; f1_value = 32'd7;
    repeat (3) @(negedge clock);
    #3;
    chk("rst_valid",  data_valid, 0);
    chk("rst_dout",   data_out, 0);
    chk("rst_ovr",    overrun, 0);
    chk("rst_strobe", bit_strobe, 0);
    chk("rst_fe",     framing_error, 0);
    chk("rst_cl",     carrier_lost, 0);
    chk("rst_state",  dut.state, 0);
    clear = 1'b0;
    @(negedge clock);
    enable = 1'b1; skip = 1'b1;

    // 1: idle mark, then clean 0xA5
    s_fe = n_fe; s_cl = n_cl; s_v = n_vcyc;
    repeat (3) win(0, 5);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    win(0, 5); #2;
    chk("t1_q",       exp_q.size(), 0);
    chk("t1_vcyc",    n_vcyc - s_v, 1);
    chk("t1_fe",      n_fe - s_fe, 0);
    chk("t1_cl",      n_cl - s_cl, 0);
    chk("t1_strobes", n_strobe, exp_strobe);

    // 2: bad stop bit
    s_fe = n_fe; s_cl = n_cl; s_v = n_vcyc;
    send_frame(8'hA5, 1'b0);
    win(0, 5); #2;
    chk("t2_fe",    n_fe - s_fe, 1);
    chk("t2_cl",    n_cl - s_cl, 0);
    chk("t2_vcyc",  n_vcyc - s_v, 0);
    chk("t2_state", dut.state, 0);

    // 3: ambiguous window mid-data, then clean 0x3C
    s_fe = n_fe; s_cl = n_cl; s_v = n_vcyc;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    win(3, 2);
    win(0, 5);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    win(0, 5); #2;
    chk("t3_cl",      n_cl - s_cl, 1);
    chk("t3_fe",      n_fe - s_fe, 0);
    chk("t3_vcyc",    n_vcyc - s_v, 1);
    chk("t3_q",       exp_q.size(), 0);
    chk("t3_strobes", n_strobe, exp_strobe);

    // 4: stalled consumer, second byte dropped
    data_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    win(0, 5); #2;
    chk("t4_dout",  data_out, 8'h11);
    chk("t4_valid", data_valid, 1);
    chk("t4_ovr",   overrun, 1);
    @(negedge clock);
    data_ready = 1'b1;
    repeat (9) @(negedge clock);
    win(0, 5); #2;
    chk("t4_q",      exp_q.size(), 0);
    chk("t4_valid2", data_valid, 0);
    chk("t4_ovr2",   overrun, 1);

    // 5: mark counter wraps through 2^32
    @(negedge clock);
    enable = 1'b0;
    repeat (4) @(negedge clock);
    f1_value = 32'hFFFF_FFFE;
    @(negedge clock);
    enable = 1'b1; skip = 1'b1;
    win(0, 0);
    s_s = n_strobe;
    win(0, 5); #2;
    chk("t5_wrap_strobe", n_strobe - s_s, 1);
    chk("t5_wrap_bit",    last_bit, 1);
    exp_q.push_back(8'h80);
    send_frame(8'h80, 1'b1);
    win(0, 5); #2;
    chk("t5_q",   exp_q.size(), 0);
    chk("t5_ovr", overrun, 1);

    // 6: asynchronous clear mid-frame, then 0x5A
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    #2 clear = 1'b1;
    #1;
    chk("t6_valid",  data_valid, 0);
    chk("t6_dout",   data_out, 0);
    chk("t6_ovr",    overrun, 0);
    chk("t6_strobe", bit_strobe, 0);
    chk("t6_state",  dut.state, 0);
    #2 clear = 1'b0;
    skip = 1'b1;
    s_fe = n_fe; s_cl = n_cl; s_v = n_vcyc;
    win(0, 5);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    win(0, 5); #2;
    chk("t6_q",    exp_q.size(), 0);
    chk("t6_vcyc", n_vcyc - s_v, 1);
    chk("t6_fe",   n_fe - s_fe, 0);
    chk("t6_cl",   n_cl - s_cl, 0);

    chk("strobes_total", n_strobe, exp_strobe);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsk_byte_decoder.md
Name: fsk_byte_decoder

Overview:
- Sits directly downstream of frequency_analyzer; consumes its cumulative per-tone counters f0_value (space, bit 0) and f1_value (mark, bit 1).
- Every bit window it differences both counters, decides 0/1/no-carrier, and frames bits UART-style (start 0, 8 data LSB-first, stop 1).
- Delivers bytes over a valid/ready handshake and flags framing, carrier-loss and overrun events.

Parameters:
CLOCK_FREQUENCY, 100000000, clock rate in Hz.
BAUD_RATE, 1000, bits per second. BIT_CLOCKS = CLOCK_FREQUENCY/BAUD_RATE; elaboration error if < 4.
MIN_MARGIN, 2, minimum count difference between tone deltas for a valid decision.
DATA_BITS, 8, data bits per frame.

Ports:
clock  in  1  system clock, rising edge.
clear  in  1  asynchronous active-high reset.
enable  in  1  run; low = hold idle.
f0_value  in  32  cumulative space-tone count from frequency_analyzer.
f1_value  in  32  cumulative mark-tone count from frequency_analyzer.
data_out  out  DATA_BITS  received byte.
data_valid  out  1  data_out holds an unconsumed byte.
data_ready  in  1  consumer accepts byte.
bit_strobe  out  1  one-cycle pulse per decided bit.
bit_value  out  1  decided bit, valid with bit_strobe.
framing_error  out  1  one-cycle pulse: stop bit decoded as 0.
carrier_lost  out  1  one-cycle pulse: ambiguous window inside a frame.
overrun  out  1  sticky: byte dropped because the holding register was full.

Behaviour:
- Reset: all outputs 0. Window counter, snapshots, shift register and primed flag cleared. FSM = IDLE.
- Window counter wcnt counts 0..BIT_CLOCKS-1 while enable=1, then wraps.
- Window end (wcnt = BIT_CLOCKS-1):
  - d0 = f0_value - prev0 and d1 = f1_value - prev1, modulo 2^32, so counter wrap is harmless.
  - prev0/prev1 are then loaded with the current values.
- Decision, registered one cycle after window end:
  - d1 >= d0 + MIN_MARGIN gives 1.
  - d0 >= d1 + MIN_MARGIN gives 0.
  - Anything else is ambiguous.
  - Comparisons use 33-bit arithmetic so no overflow is possible.
  - Ambiguous windows produce no bit_strobe.
- Primed flag: the first window after reset or after enable rises is discarded (no strobe, no FSM action); the flag sets at that window's end.
- Latency: bit_strobe/bit_value one cycle after window end. FSM acts on the strobe cycle, so its outputs appear the following cycle.
- FSM:
  - IDLE: bit 0 moves to DATA (start bit consumed) with bit index 0. Bit 1 and ambiguous windows stay in IDLE.
  - DATA: shift bit in LSB-first and increment the index. After DATA_BITS bits move to STOP. An ambiguous window pulses carrier_lost and returns to IDLE, discarding partial data.
  - STOP:
    - bit 1: load the byte and return to IDLE.
    - bit 0: pulse framing_error, discard the byte, return to IDLE (this 0 is not treated as a new start bit).
    - ambiguous window: pulse carrier_lost and return to IDLE.
- Handshake and holding register:
  - A byte transfers on any cycle with data_valid & data_ready; data_valid falls the next cycle.
  - Load with data_valid=0, or with data_valid=1 and data_ready=1 in the same cycle: data_out updates and data_valid stays/goes 1 (load has priority over the clear from the transfer).
  - Load with data_valid=1 and data_ready=0: the new byte is dropped, overrun is set, and data_out is unchanged.
- overrun clears only on clear.
- enable=0: wcnt held at 0, FSM forced to IDLE, partial byte discarded, primed cleared. prev0/prev1 track f0_value/f1_value every cycle, so re-enable causes no stale delta. The holding register and its handshake stay fully operational.
- clear mid-frame: everything returns to reset values immediately (asynchronous), including data_valid and overrun.

Decomposition:
- Shared package/include fsk_decoder_defs: FSM state encodings (IDLE=0, DATA=1, STOP=2), decision encodings (BIT0, BIT1, AMBIG), and the BIT_CLOCKS derivation function.
- Sub-module fsk_window_decider: window counter, snapshots, modular deltas, margin compare, primed flag. Outputs strobe, value and ambiguous-pulse to the framing FSM in the top.

Test Plan (CLOCK_FREQUENCY=1000, BAUD_RATE=100 so BIT_CLOCKS=10, MIN_MARGIN=2, data_ready=1 unless stated):
1. Bench increments f1 by 5 and f0 by 0 per window for 3 windows, then sends frame 0xA5 (tone per bit: start 0, 1,0,1,0,0,1,0,1 LSB-first, stop 1) -> data_out=0xA5, data_valid for exactly 1 cycle, one cycle after the stop-bit strobe; no error pulses.
2. Same frame, but the stop window uses f0 +5 -> framing_error pulses once, data_valid stays 0, FSM in IDLE.
3. Mid-DATA window with d0=3, d1=2 (margin not met) -> carrier_lost pulses, no bit_strobe for that window, next valid frame 0x3C decodes correctly.
4. Hold data_ready=0, send 0x11 then 0x22 -> data_out=0x11 held, overrun=1; set data_ready=1 -> 0x11 transfers, overrun stays 1 until clear.
5. Preload f1_value=32'hFFFFFFFE and step by 5 per window across the 2^32 wrap -> deltas equal 5, bits decoded as 1, frame 0x80 received intact.
6. Assert clear for 3 ns mid-DATA, then run frame 0x5A -> all outputs 0 immediately; first post-reset window discarded; 0x5A received afterwards.
